// File: rtl/tmatch_sad_scorer_pkg.sv
// Shared definitions for the template-matching SAD scorer family:
// default geometry, the scorer state encoding and the score-width helper.
package tmatch_pkg;

    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A full template of maximum-difference bytes sums to at most
    // 2^aw * (2^dw - 1), which always fits in aw+dw bits.
    function automatic int score_w(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/tmatch_sad_scorer_if.sv
// Bundle of the scorer's control, feature-stream, template-ROM and result
// signals. The slave side is the scorer; the master side is its environment
// (control logic, feature source, ROM and decision logic).
interface tmatch_sad_scorer_if
    import tmatch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SCORE_W    = score_w(ADDR_WIDTH_DEF, DATA_WIDTH_DEF)
);
    logic                  start;
    logic                  busy;
    logic                  feat_valid;
    logic                  feat_ready;
    logic [DATA_WIDTH-1:0] feat_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [SCORE_W-1:0]    thresh;
    logic [SCORE_W-1:0]    score;
    logic                  score_valid;
    logic                  match;

    modport slave (
        input  start, feat_valid, feat_data, rom_data, thresh,
        output busy, feat_ready, rom_addr, score, score_valid, match
    );

    modport master (
        output start, feat_valid, feat_data, rom_data, thresh,
        input  busy, feat_ready, rom_addr, score, score_valid, match
    );
endinterface

// File: rtl/tmatch_sad_scorer_absdiff.sv
// Combinational |a - b| on unsigned bytes. With TMATCH_MASK_EN defined a
// template byte (i_b) of zero marks a don't-care pixel and yields 0.
module tmatch_absdiff #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_diff
);
    logic [DATA_WIDTH-1:0] w_mag;

    // Subtract the smaller from the larger so the result is never negative.
    assign w_mag = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

`ifdef TMATCH_MASK_EN
    assign o_diff = (i_b == '0) ? '0 : w_mag;
`else
    assign o_diff = w_mag;
`endif

endmodule

// File: rtl/tmatch_sad_scorer.sv
// SAD scorer: walks the template ROM in lock-step with accepted feature
// bytes, accumulates |feature - template| and reports score / match.
// Optional build macro: TMATCH_MASK_EN (template byte 0 = don't-care pixel).
module tmatch_sad_scorer
    import tmatch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int SCORE_W    = score_w(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    tmatch_sad_scorer_if.slave bus
);
    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_feat_d1;
    logic                  r_d1;
    logic [SCORE_W-1:0]    r_acc;
    logic [SCORE_W-1:0]    r_thresh;
    logic [SCORE_W-1:0]    r_score;
    logic                  r_match;

    logic                  w_feat_ready;
    logic [ADDR_WIDTH-1:0] w_rom_addr;
    logic                  w_busy;
    logic                  w_score_valid;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [SCORE_W-1:0]    w_acc_sum;

    assign w_accept  = bus.feat_valid & w_feat_ready;
    assign w_last    = (r_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign w_acc_sum = r_acc + SCORE_W'(w_diff);

    // The delayed feature byte meets the ROM byte read for the same address.
    tmatch_absdiff #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_absdiff (
        .i_a    (r_feat_d1),
        .i_b    (bus.rom_data),
        .o_diff (w_diff)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: start only honoured in IDLE; DRAIN and DONE last one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)          w_state_next = RUN;
            RUN:     if (w_accept && w_last) w_state_next = DRAIN;
            DRAIN:                           w_state_next = DONE;
            DONE:                            w_state_next = IDLE;
            default:                         w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs; the ROM address only walks while running.
    always_comb begin
        w_feat_ready  = 1'b0;
        w_rom_addr    = '0;
        w_busy        = 1'b0;
        w_score_valid = 1'b0;
        case (r_state)
            RUN: begin
                w_feat_ready = 1'b1;
                w_rom_addr   = r_cnt;
                w_busy       = 1'b1;
            end
            DRAIN:   w_busy = 1'b1;
            DONE: begin
                w_busy        = 1'b1;
                w_score_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter, one-stage feature delay, accumulator and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_feat_d1 <= '0;
            r_d1      <= 1'b0;
            r_acc     <= '0;
            r_thresh  <= '0;
            r_score   <= '0;
            r_match   <= 1'b0;
        end else begin
            r_d1 <= w_accept;
            if (w_accept) begin
                r_feat_d1 <= bus.feat_data;
                r_cnt     <= r_cnt + ADDR_WIDTH'(1);
            end
            if (r_state == IDLE && bus.start) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_thresh <= bus.thresh;
            end else if (r_d1) begin
                r_acc <= w_acc_sum;
            end
            // The last byte's difference is still in flight during DRAIN.
            if (r_state == DRAIN) begin
                r_score <= w_acc_sum;
                r_match <= (w_acc_sum <= r_thresh);
            end
        end
    end

    assign bus.feat_ready  = w_feat_ready;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.busy        = w_busy;
    assign bus.score_valid = w_score_valid;
    assign bus.score       = r_score;
    assign bus.match       = r_match;

endmodule

// File: tb/tb_tmatch_sad_scorer.sv
// Self-checking bench for tmatch_sad_scorer: ROM model, randomized feature
// gaps and data, and a plain-arithmetic SAD reference.
module tb_tmatch_sad_scorer;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;
    localparam int SW    = 19;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] tmpl [0:DEPTH-1];
    logic [DW-1:0] feat [0:DEPTH-1];

    tmatch_sad_scorer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCORE_W(SW)) bus ();

    tmatch_sad_scorer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SCORE_W    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous template ROM, one-cycle read latency.
    always @(posedge clk) bus.rom_data <= tmpl[bus.rom_addr];

    // Reference: sum of per-pixel absolute differences over the whole frame.
    function automatic int model_sad();
        int s;
        s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int t, f, d;
            t = int'(tmpl[i]);
            f = int'(feat[i]);
            d = (f > t) ? f - t : t - f;
`ifdef TMATCH_MASK_EN
            if (t == 0) d = 0;
`endif
            s += d;
        end
        return s;
    endfunction

    task automatic fill_const(input logic [DW-1:0] t, input logic [DW-1:0] f);
        for (int i = 0; i < DEPTH; i++) begin
            tmpl[i] = t;
            feat[i] = f;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            tmpl[i] = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
            feat[i] = 8'($urandom);
        end
    endtask

    // One frame: start, stream with random idle cycles, check result timing.
    task automatic run_frame(input string name, input int idle_pct,
                             input logic [SW-1:0] th, input bit poke);
        int       idx, cyc, addr_bad, sv_run, exp_s;
        logic     exp_m;
        bit       v;
        exp_s = model_sad();
        exp_m = (exp_s <= int'(th));

        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_busy got=%b want=0", name, bus.busy);
        end
        bus.thresh     = th;
        bus.start      = 1'b1;
        bus.feat_valid = 1'b1;          // must be ignored outside RUN
        bus.feat_data  = 8'($urandom);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.thresh = ~th;               // threshold must already be latched
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_busy got=%b want=1", name, bus.busy);
        end

        idx = 0; cyc = 0; addr_bad = 0; sv_run = 0;
        while (idx < DEPTH && cyc < 20000) begin
            if (bus.rom_addr !== AW'(idx)) addr_bad++;
            if (bus.score_valid === 1'b1) sv_run++;
            v = ($urandom_range(99) >= idle_pct);
            bus.feat_valid = v;
            bus.feat_data  = v ? feat[idx] : 8'($urandom);
            bus.start      = (poke && idx == 100) ? 1'b1 : 1'b0;
            if (v && bus.feat_ready === 1'b1) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.feat_valid = 1'b0;
        bus.start      = 1'b0;

        n_checks++;
        if (idx < DEPTH) begin
            n_fail++;
            $display("FAIL %s stream_timeout accepted=%0d want=%0d", name, idx, DEPTH);
            return;
        end
        n_checks++;
        if (addr_bad !== 0 || sv_run !== 0) begin
            n_fail++;
            $display("FAIL %s addr_track bad_addr=%0d early_valid=%0d want=0/0",
                     name, addr_bad, sv_run);
        end
        // First cycle after the last accept: DRAIN.
        n_checks++;
        if (bus.score_valid !== 1'b0 || bus.feat_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drain_cycle valid=%b ready=%b busy=%b want=0/0/1",
                     name, bus.score_valid, bus.feat_ready, bus.busy);
        end
        @(negedge clk);
        // Second cycle: DONE with the result.
        n_checks++;
        if (bus.score_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid_latency got=%b want=1", name, bus.score_valid);
        end
        n_checks++;
        if (bus.score !== SW'(exp_s) || bus.match !== exp_m) begin
            n_fail++;
            $display("FAIL %s score got=%0d/%b want=%0d/%b",
                     name, bus.score, bus.match, exp_s, exp_m);
        end
        if (poke) bus.start = 1'b1;     // start during DONE must be ignored
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.score_valid !== 1'b0 ||
            bus.score !== SW'(exp_s) || bus.match !== exp_m) begin
            n_fail++;
            $display("FAIL %s after_done busy=%b valid=%b score=%0d want busy=0 valid=0 score=%0d",
                     name, bus.busy, bus.score_valid, bus.score, exp_s);
        end
        $display("frame %s: score=%0d match=%b expected=%0d/%b cycles=%0d",
                 name, bus.score, bus.match, exp_s, exp_m, cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.feat_valid = 1'b0; bus.feat_data = '0; bus.thresh = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.feat_ready !== 1'b0 || bus.rom_addr !== '0 ||
            bus.score !== '0 || bus.score_valid !== 1'b0 || bus.match !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b ready=%b addr=%0d score=%0d valid=%b match=%b want all 0",
                     bus.busy, bus.feat_ready, bus.rom_addr, bus.score, bus.score_valid, bus.match);
        end
        rst = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_equal();
        fill_const(8'h10, 8'h10);
        run_frame("equal", 0, 19'd0, 1'b0);
    endtask

    task automatic test_threshold();
        fill_const(8'h10, 8'h20);
        run_frame("thresh_below", 0, 19'd32767, 1'b0);
        run_frame("thresh_equal", 0, 19'd32768, 1'b0);
    endtask

    task automatic test_max_diff();
        fill_const(8'h00, 8'hFF);
        run_frame("max_diff", 0, 19'd0, 1'b0);
    endtask

    task automatic test_gaps();
        fill_const(8'h10, 8'h20);
        run_frame("gaps", 40, 19'd32768, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_frame("start_ignored", 20, 19'($urandom_range(300000, 200000)), 1'b1);
    endtask

    task automatic test_reset_mid();
        int idx, cyc;
        fill_const(8'h10, 8'h20);
        @(negedge clk);
        bus.thresh = 19'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 1000 && cyc < 10000) begin
            bus.feat_valid = ($urandom_range(99) >= 30);
            bus.feat_data  = feat[idx];
            if (bus.feat_valid && bus.feat_ready === 1'b1) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.feat_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (idx < 1000 || bus.busy !== 1'b0 || bus.score !== '0 || bus.match !== 1'b0 ||
            bus.feat_ready !== 1'b0 || bus.rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid accepted=%0d busy=%b score=%0d match=%b ready=%b addr=%0d want 1000 and all 0",
                     idx, bus.busy, bus.score, bus.match, bus.feat_ready, bus.rom_addr);
        end
        $display("reset_mid: aborted after %0d bytes", idx);
        fill_random();
        run_frame("after_reset", 10, 19'($urandom_range(300000, 200000)), 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            fill_random();
            run_frame("random", 25, 19'(model_sad() - 1 + k), 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_equal();
        test_threshold();
        test_max_diff();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmatch_sad_scorer.md
Name: tmatch_sad_scorer

Overview:
- Scores one incoming feature frame against a fruit template held in the synchronous template ROM. Sits directly upstream of that ROM.
- Walks the ROM address in lock-step with an accepted feature byte stream and accumulates the sum of absolute differences (SAD).
- Reports the SAD score and a match flag against a runtime threshold to the fruit-decision logic.
- One instance per fruit template (e.g. one per mango ROM).

Parameters:
- ADDR_WIDTH, 11, template ROM address width.
- DATA_WIDTH, 8, feature/template byte width.
- DEPTH, 2048, template length in bytes; legal range 1..2^ADDR_WIDTH.
- SCORE_W, ADDR_WIDTH+DATA_WIDTH (19), accumulator/score width; sized so no overflow occurs for DEPTH ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to score a new frame; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE completes.
- feat_valid  in  1  feature byte valid.
- feat_ready  out  1  block accepts a feature byte.
- feat_data  in  DATA_WIDTH  feature byte, raster order.
- rom_addr  out  ADDR_WIDTH  template ROM address; ROM read latency is one cycle.
- rom_data  in  DATA_WIDTH  template byte for the address presented on the previous cycle.
- thresh  in  SCORE_W  match threshold, sampled at start.
- score  out  SCORE_W  final SAD; held until the next DONE.
- score_valid  out  1  one-cycle pulse when score and match are updated.
- match  out  1  score ≤ latched threshold; held with score.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; counter, accumulator and latched threshold are 0.
- State IDLE:
  - feat_ready=0, rom_addr=0.
  - start=1 → clear accumulator, cnt=0, latch thresh, go to RUN.
- State RUN:
  - feat_ready=1 and rom_addr=cnt.
  - Accept = feat_valid & feat_ready. On accept, feat_data is registered into a one-stage delay with a valid tag d1, and cnt increments.
  - No accept → cnt holds and d1 is cleared. The ROM re-reads the same address, which is harmless.
  - Accept with cnt==DEPTH-1 → go to DRAIN.
- Data stage (every cycle):
  - If d1=1: acc <= acc + |feat_d1 - rom_data|, computed unsigned on DATA_WIDTH+1 bits and zero-extended to SCORE_W.
- State DRAIN:
  - Lasts one cycle; feat_ready=0.
  - At the end of DRAIN the final byte is accumulated: score <= acc + diff, match <= (acc + diff ≤ thresh_latched). Go to DONE.
- State DONE:
  - Lasts one cycle; score_valid=1.
  - start is ignored. Go to IDLE.
- Latency: score_valid is high in the 2nd cycle after the edge that accepts the last byte.
- busy=1 in RUN, DRAIN and DONE.
- start while busy is ignored entirely; there is no queueing.
- DEPTH=1: the first accept goes directly to DRAIN.
- feat_valid held low indefinitely in RUN: the block waits with no timeout.
- rst at any time: returns to IDLE on the next edge. Outputs are cleared, including a held score/match, and a partial frame is discarded.
- feat_data outside RUN is ignored.

Optional Feature:
- Macro TMATCH_MASK_EN.
- Defined: a template byte equal to 0 marks a don't-care pixel. Its diff is forced to 0, so masked pixels contribute nothing to the score.
- Not defined: every pixel contributes |feat - template|, including template value 0.
- Handshake, latency and port list are identical in both builds.

Decomposition:
- Package tmatch_pkg holds:
  - Default ADDR_WIDTH, DATA_WIDTH and DEPTH constants.
  - The state enum: IDLE, RUN, DRAIN, DONE.
  - A function computing SCORE_W.
- Sub-module tmatch_absdiff is natural: combinational |a-b| with the optional mask, reused by sibling scorers.
- The FSM, counter, delay stage and accumulator stay in the top module.

Test Plan:
- Template all 0x10, features all 0x10, thresh=0, feat_valid always 1 → score=0, match=1, score_valid exactly 2 cycles after the edge accepting byte 2047.
- Template all 0x10, features all 0x20 → score=32768 (0x08000). With thresh=32767 → match=0; with thresh=32768 → match=1.
- Template all 0x00, features all 0xFF, mask undefined → score=522240 (0x7F800), no overflow. With TMATCH_MASK_EN → score=0.
- Same stimulus as case 2 with random feat_valid gaps (≈40% idle) → score=32768; rom_addr never advances on a non-accept cycle.
- start pulsed during RUN and during DONE → ignored; exactly one score_valid per accepted start; cnt unaffected.
- rst asserted after 1000 accepted bytes → next cycle IDLE, busy=0, score=0. A fresh start then with 2048 bytes gives the correct score.
